// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: steps one register-register ALU op through Y-load, execute and Z write-back.
// Latency: start sampled at edge N, done high for one cycle after edge N+3 (N+4 for wide ops).
// Backpressure: start is ignored while busy; a start in the done cycle is accepted (no idle gap).
// Optional feature macro: ZHI_WB_EN (MUL_OP/DIV_OP write Z low/high into LO/HI).
module alu_op_sequencer #(
    parameter int NREG = 16,
    parameter int OPW = 5,
    parameter logic [OPW-1:0] MUL_OP = 5'b01110,
    parameter logic [OPW-1:0] DIV_OP = 5'b01111,
    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            Clock,
    input  logic            clear,
    input  logic            start,
    input  logic [RW-1:0]   ra,
    input  logic [RW-1:0]   rb,
    input  logic [RW-1:0]   rd,
    input  logic [OPW-1:0]  op,
    output logic            busy,
    output logic            done,
    output logic [NREG-1:0] Rout,
    output logic [NREG-1:0] Rin,
    output logic            Yin,
    output logic            Zin,
    output logic            Zlowout,
    output logic            Zhighout,
    output logic            HIin,
    output logic            LOin,
    output logic [OPW-1:0]  op_out
);

`ifdef ZHI_WB_EN
    typedef enum logic [2:0] {IDLE, YLD, EXE, WBL, WBH} state_t;
`else
    typedef enum logic [1:0] {IDLE, YLD, EXE, WBL} state_t;
`endif

    state_t         state_q, state_d;
    logic [RW-1:0]  ra_q, rb_q, rd_q;
    logic [OPW-1:0] op_q;
    logic           done_q;
    logic           last_wb;
    logic           wide;

    // Index to one-hot strobe; indices beyond the register file select nothing.
    function automatic logic [NREG-1:0] onehot(input logic [RW-1:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            v[i] = (int'(idx) == i);
        end
        return v;
    endfunction

`ifdef ZHI_WB_EN
    assign wide = (op_q == MUL_OP) || (op_q == DIV_OP);
`else
    // MUL/DIV codes only matter to the HI/LO write-back path, absent in this build.
    logic unused_wide_ops;
    assign unused_wide_ops = ^{MUL_OP, DIV_OP};
    assign wide = 1'b0;
`endif

    // State register and the registered done pulse (one cycle after the last write-back).
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= last_wb;
        end
    end

    // Operand/opcode capture: only taken when a request is accepted in IDLE.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            ra_q <= '0;
            rb_q <= '0;
            rd_q <= '0;
            op_q <= '0;
        end else if (state_q == IDLE && start) begin
            ra_q <= ra;
            rb_q <= rb;
            rd_q <= rd;
            op_q <= op;
        end
    end

    // Next state and strobe decode; strobes depend only on state and captured fields.
    always_comb begin
        state_d  = state_q;
        last_wb  = 1'b0;
        Rout     = '0;
        Rin      = '0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        op_out   = '0;
        case (state_q)
            IDLE: begin
                if (start) state_d = YLD;
            end
            YLD: begin
                Rout    = onehot(ra_q);
                Yin     = 1'b1;
                state_d = EXE;
            end
            EXE: begin
                Rout    = onehot(rb_q);
                Zin     = 1'b1;
                op_out  = op_q;
                state_d = WBL;
            end
            WBL: begin
                Zlowout = 1'b1;
                if (wide) begin
                    LOin = 1'b1;
`ifdef ZHI_WB_EN
                    state_d = WBH;
`endif
                end else begin
                    Rin     = onehot(rd_q);
                    state_d = IDLE;
                    last_wb = 1'b1;
                end
            end
`ifdef ZHI_WB_EN
            WBH: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = IDLE;
                last_wb  = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        clear, start;
    logic [3:0]  ra, rb, rd;
    logic [4:0]  op;
    logic        busy, done, Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic [15:0] Rout, Rin;
    logic [4:0]  op_out;

    logic        start12;
    logic [3:0]  ra12, rb12, rd12;
    logic [4:0]  op12, opo12;
    logic        busy12, done12, yin12, zin12, zlo12, zhi12, hiin12, loin12;
    logic [11:0] rout12, rin12;

    int ncmp = 0;
    int nerr = 0;

    alu_op_sequencer #(.NREG(16)) u_dut (
        .Clock(Clock), .clear(clear), .start(start), .ra(ra), .rb(rb), .rd(rd), .op(op),
        .busy(busy), .done(done), .Rout(Rout), .Rin(Rin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .op_out(op_out)
    );

    alu_op_sequencer #(.NREG(12)) u_n12 (
        .Clock(Clock), .clear(clear), .start(start12), .ra(ra12), .rb(rb12), .rd(rd12), .op(op12),
        .busy(busy12), .done(done12), .Rout(rout12), .Rin(rin12), .Yin(yin12), .Zin(zin12),
        .Zlowout(zlo12), .Zhighout(zhi12), .HIin(hiin12), .LOin(loin12), .op_out(opo12)
    );

    // Observed outputs of one cycle, all fields zero means idle.
    typedef struct packed {
        logic        busy;
        logic        done;
        logic [15:0] rout;
        logic [15:0] rin;
        logic        yin, zin, zlo, zhi, hiin, loin;
        logic [4:0]  op;
    } obs_t;

    // Reference model: a queue of expected per-cycle outputs for the cycles ahead.
    obs_t exp_q[$];

    function automatic logic is_wide(input logic [4:0] o);
        logic w;
        w = 1'b0;
`ifdef ZHI_WB_EN
        w = (o == 5'b01110) || (o == 5'b01111);
`endif
        return w;
    endfunction

    task automatic push_seq(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                            input logic [4:0] o);
        obs_t r;
        r = '0; r.busy = 1'b1; r.rout = 16'd1 << a; r.yin = 1'b1;
        exp_q.push_back(r);
        r = '0; r.busy = 1'b1; r.rout = 16'd1 << b; r.zin = 1'b1; r.op = o;
        exp_q.push_back(r);
        r = '0; r.busy = 1'b1; r.zlo = 1'b1;
        if (is_wide(o)) begin
            r.loin = 1'b1;
            exp_q.push_back(r);
            r = '0; r.busy = 1'b1; r.zhi = 1'b1; r.hiin = 1'b1;
            exp_q.push_back(r);
        end else begin
            r.rin = 16'd1 << d;
            exp_q.push_back(r);
        end
        r = '0; r.done = 1'b1;
        exp_q.push_back(r);
    endtask

    always @(posedge Clock) begin
        obs_t cur;
        if (!clear) begin
            exp_q.delete();
        end else begin
            cur = (exp_q.size() != 0) ? exp_q[0] : obs_t'('0);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (start && !cur.busy) push_seq(ra, rb, rd, op);
        end
    end

    function automatic obs_t act_obs();
        obs_t a;
        a.busy = busy; a.done = done; a.rout = Rout; a.rin = Rin;
        a.yin = Yin; a.zin = Zin; a.zlo = Zlowout; a.zhi = Zhighout;
        a.hiin = HIin; a.loin = LOin; a.op = op_out;
        return a;
    endfunction

    task automatic check_obs(input string nm, input obs_t e);
        obs_t a;
        a = act_obs();
        ncmp++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: outputs got %h, expected %h", nm, a, e);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic tick(input string nm);
        obs_t e;
        @(posedge Clock);
        #1;
        e = '0;
        if (clear && exp_q.size() != 0) e = exp_q[0];
        check_obs(nm, e);
    endtask

    typedef struct {
        logic [3:0]  ra, rb, rd;
        logic [4:0]  op;
        logic [15:0] rout_y, rout_e, rin_w;
        int          lat;
    } vec_t;

    vec_t vt[4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, nd, d1, d2;

        vt[0] = '{4'd3, 4'd2, 4'd1,  5'b00110, 16'h0008, 16'h0004, 16'h0002, 4};
        vt[1] = '{4'd0, 4'd15, 4'd15, 5'b00001, 16'h0001, 16'h8000, 16'h8000, 4};
        vt[2] = '{4'd5, 4'd5, 4'd5,  5'b10101, 16'h0020, 16'h0020, 16'h0020, 4};
`ifdef ZHI_WB_EN
        vt[3] = '{4'd4, 4'd5, 4'd7,  5'b01110, 16'h0010, 16'h0020, 16'h0000, 5};
`else
        vt[3] = '{4'd4, 4'd5, 4'd7,  5'b01110, 16'h0010, 16'h0020, 16'h0080, 4};
`endif

        clear = 1'b0; start = 1'b0; ra = 4'd9; rb = 4'd3; rd = 4'd6; op = 5'd7;
        start12 = 1'b0; ra12 = '0; rb12 = '0; rd12 = '0; op12 = '0;
        #12;
        check_obs("reset_state", '0);
        chk("reset_n12", 32'({busy12, done12, rout12, rin12}), 32'd0);
        @(posedge Clock); #1;
        clear = 1'b1;
        tick("post_reset_idle");

        // Table-driven single operations.
        for (int i = 0; i < 4; i++) begin
            ra = vt[i].ra; rb = vt[i].rb; rd = vt[i].rd; op = vt[i].op; start = 1'b1;
            tick("tbl_model_yld");
            start = 1'b0;
            chk("tbl_yld", 32'({Rout, Yin}), 32'({vt[i].rout_y, 1'b1}));
            tick("tbl_model_exe");
            chk("tbl_exe", 32'({Rout, Zin, op_out}), 32'({vt[i].rout_e, 1'b1, vt[i].op}));
            tick("tbl_model_wbl");
            chk("tbl_wbl", 32'({Rin, Zlowout}), 32'({vt[i].rin_w, 1'b1}));
            n = 3;
            while (!done && n < 8) begin
                tick("tbl_model_tail");
                n++;
            end
            chk("tbl_latency", 32'(n), 32'(vt[i].lat));
        end

        // Start held high: two back-to-back sequences, done pulses four cycles apart.
        ra = 4'd1; rb = 4'd2; rd = 4'd3; op = 5'b00110; start = 1'b1;
        nd = 0; d1 = 0; d2 = 0;
        for (int k = 1; k <= 12; k++) begin
            tick("b2b_model");
            if (k == 8) start = 1'b0;
            if (done) begin
                nd++;
                if (nd == 1) d1 = k;
                else if (nd == 2) d2 = k;
            end
        end
        chk("b2b_count", 32'(nd), 32'd2);
        chk("b2b_first", 32'(d1), 32'd4);
        chk("b2b_gap", 32'(d2 - d1), 32'd4);

        // Start while busy is ignored; captured operands stay as accepted.
        ra = 4'd2; rb = 4'd3; rd = 4'd4; op = 5'd1; start = 1'b1;
        tick("ign_model");
        chk("ign_yld", 32'(Rout), 32'h0004);
        ra = 4'd7; rb = 4'd7; rd = 4'd7; op = 5'h1f;
        tick("ign_model");
        start = 1'b0;
        chk("ign_exe", 32'({Rout, op_out}), 32'({16'h0008, 5'd1}));
        tick("ign_model");
        chk("ign_wbl", 32'(Rin), 32'h0010);
        tick("ign_model");
        chk("ign_done", 32'({done, busy}), 32'b10);
        tick("ign_model");
        chk("ign_idle", 32'({done, busy}), 32'b00);

        // Clear asserted during EXE drops everything at once; no write-back follows.
        ra = 4'd6; rb = 4'd1; rd = 4'd9; op = 5'd2; start = 1'b1;
        tick("clr_model");
        start = 1'b0;
        tick("clr_model");
        chk("pre_clear_exe", 32'({Zin, busy}), 32'b11);
        clear = 1'b0;
        #1;
        check_obs("clear_in_exe", '0);
        tick("clear_hold");
        clear = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick("post_clear");
            chk("post_clear_rin", 32'(Rin), 32'd0);
        end

        // NREG=12 with an out-of-range destination: no Rin, done still pulses.
        ra12 = 4'd1; rb12 = 4'd2; rd12 = 4'd13; op12 = 5'd3; start12 = 1'b1;
        tick("n12_side");
        start12 = 1'b0;
        chk("n12_yld", 32'({rout12, yin12}), 32'({12'h002, 1'b1}));
        tick("n12_side");
        tick("n12_side");
        chk("n12_wbl", 32'({rin12, zlo12}), 32'({12'h000, 1'b1}));
        tick("n12_side");
        chk("n12_done", 32'({done12, busy12}), 32'b10);

        // Randomized traffic, including occasional async clears.
        for (int k = 0; k < 400; k++) begin
            start = ($urandom_range(0, 2) != 0);
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rd = 4'($urandom_range(0, 15));
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(14, 15)) : 5'($urandom_range(0, 31));
            clear = ($urandom_range(0, 49) != 0);
            tick("rand_model");
        end
        clear = 1'b1; start = 1'b0;
        for (int k = 0; k < 6; k++) tick("drain_model");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter NREG, default 16, meaning number of general registers driven (2..32).
REQ-002 SHALL have parameter OPW, default 5, meaning ALU opcode width.
REQ-003 SHALL have parameter MUL_OP, default 5'b01110, meaning opcode producing a 64-bit Z result.
REQ-004 SHALL have parameter DIV_OP, default 5'b01111, meaning opcode producing a 64-bit Z result.
REQ-005 SHALL have port Clock  input  1  system clock, rising-edge active.
REQ-006 SHALL have port clear  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  request to run one register-register ALU op.
REQ-008 SHALL have ports ra, rb, rd  input  RW each  operand A, operand B, destination register index, where RW = max(1, clog2(NREG)).
REQ-009 SHALL have port op  input  OPW  ALU opcode for the request.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port done  output  1  single-cycle completion pulse.
REQ-012 SHALL have ports Rout, Rin  output  NREG each  one-hot register bus-drive and load strobes.
REQ-013 SHALL have ports Yin, Zin, Zlowout, Zhighout, HIin, LOin  output  1 each  datapath strobes.
REQ-014 SHALL have port op_out  output  OPW  opcode presented to the ALU.

Function
REQ-015 SHALL implement states IDLE, YLD, EXE, WBL, and WBH (WBH only when ZHI_WB_EN is defined).
REQ-016 SHALL, in IDLE, on a rising edge with start=1, capture ra/rb/rd/op and go to YLD; start=0 stays in IDLE.
REQ-017 SHALL drive Rout[ra]=1 and Yin=1 in YLD, then go to EXE.
REQ-018 SHALL drive Rout[rb]=1, Zin=1 and op_out=captured op in EXE, then go to WBL; op_out SHALL be 0 in all other states.
REQ-019 SHALL drive Zlowout=1 and Rin[rd]=1 in WBL for narrow ops, then go to IDLE.
REQ-020 SHALL decode all strobes from the state register and captured fields only, with no combinational path from start/ra/rb/rd/op.
REQ-021 SHALL assert at most one Rout bit and at most one Rin bit in any cycle; all other strobes SHALL be 0 outside their state.
REQ-022 SHALL assert no Rout/Rin bit when a captured index is >= NREG; the sequence SHALL still complete and pulse done.
REQ-023 SHALL pulse done for exactly the one cycle following the last write-back state; busy SHALL be 0 in that cycle.
REQ-024 SHALL give narrow-op latency of 4 cycles: start sampled at edge N, done high in cycle N+3..N+4.
REQ-025 SHALL ignore start while busy=1, with captured fields unchanged.
REQ-026 SHALL accept a start during the done cycle, giving back-to-back ops with no idle gap.
REQ-027 SHALL allow ra, rb and rd to be equal; behaviour is unchanged.

Reset
REQ-028 SHALL, on clear=0, immediately force state IDLE, busy=0, done=0, all strobes 0, op_out=0, and captured fields 0, including mid-operation.
REQ-029 SHALL start no sequence in the first edge after clear deasserts unless start=1 at that edge.

Configuration
REQ-030 SHALL, with ZHI_WB_EN defined, handle captured op equal to MUL_OP or DIV_OP as follows: WBL drives Zlowout=1 and LOin=1 with no Rin; then WBH drives Zhighout=1 and HIin=1; then IDLE. Latency is 5 cycles.
REQ-031 SHALL, without ZHI_WB_EN, have no WBH state, never assert Zhighout/HIin/LOin, and treat MUL_OP/DIV_OP as narrow ops.

Verification
REQ-032 SHALL cover: ra=3, rb=2, rd=1, op=5'b00110 (ROL) -> Rout=0x0008+Yin, then Rout=0x0004+Zin+op_out=6, then Zlowout+Rin=0x0002, then done=1.
REQ-033 SHALL cover: start held high for 8 cycles, op=5'b00110 -> two back-to-back sequences, done pulses 4 cycles apart, no idle gap.
REQ-034 SHALL cover: clear=0 asserted during EXE -> Zin, Rout, op_out and busy drop to 0 in the same cycle; no Rin pulse follows.
REQ-035 SHALL cover, with ZHI_WB_EN: op=5'b01110, ra=4, rb=5 -> WBL asserts LOin+Zlowout, WBH asserts HIin+Zhighout, Rin stays 0, and done follows 5 cycles after start.
REQ-036 SHALL cover: NREG=12, rd=13 -> WBL asserts Zlowout with Rin=0, and done still pulses.
REQ-037 SHALL cover: start pulsed while busy, with ra=7 -> ignored; the current op completes using the originally captured ra.
